// File: rtl/write_ptr_full_ctrl.sv
// Write-side pointer and flag controller for an async FIFO.
// Owns the binary/Gray write pointer and produces full, almost-full, level and sticky overflow.
module write_ptr_full_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                  w_clk_in,
    input  logic                  w_reset_in,
    input  logic                  w_request_in,
    input  logic [ADDR_WIDTH:0]   r_ptr_gray_sync_in,
    output logic                  w_en_out,
    output logic [ADDR_WIDTH-1:0] w_addr_out,
    output logic [ADDR_WIDTH:0]   w_ptr_gray_out,
    output logic                  ctrl_full_out,
    output logic                  ctrl_almost_full_out,
    output logic [ADDR_WIDTH:0]   w_level_out,
    output logic                  w_overflow_out
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ALMOST = 2'd1,
        ST_FULL   = 2'd2
    } flag_state_t;

    flag_state_t   state_q, state_d;
    logic [PW-1:0] w_bin_q, w_bin_d;
    logic [PW-1:0] w_gray_q, w_gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] full_match;
    logic          full_d;
    logic          af_d;
    logic          w_en;

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign r_bin[gi] = ^r_ptr_gray_sync_in[ADDR_WIDTH:gi];
        end
    endgenerate

    // The write pointer is exactly one lap ahead when its two MSBs are inverted in Gray form.
    assign full_match = {~r_ptr_gray_sync_in[ADDR_WIDTH:ADDR_WIDTH-1],
                         r_ptr_gray_sync_in[ADDR_WIDTH-2:0]};

    assign ctrl_full_out = (state_q == ST_FULL);
    assign w_en          = w_request_in & ~ctrl_full_out & ~w_reset_in;

    always_comb begin
        w_bin_d    = w_bin_q + {{ADDR_WIDTH{1'b0}}, w_en};
        w_gray_d   = w_bin_d ^ (w_bin_d >> 1);
        full_d     = (w_gray_d == full_match);
        level_d    = w_bin_d - r_bin;
        af_d       = (level_d >= AF_LEVEL);
        overflow_d = overflow_q | (w_request_in & ctrl_full_out);
        state_d    = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (full_d)    state_d = ST_FULL;
                else if (af_d) state_d = ST_ALMOST;
            end
            ST_ALMOST: begin
                if (full_d)     state_d = ST_FULL;
                else if (!af_d) state_d = ST_NORMAL;
            end
            ST_FULL: begin
                if (!full_d) state_d = af_d ? ST_ALMOST : ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge w_clk_in) begin
        if (w_reset_in) begin
            state_q    <= ST_NORMAL;
            w_bin_q    <= '0;
            w_gray_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_bin_q    <= w_bin_d;
            w_gray_q   <= w_gray_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign w_en_out             = w_en;
    assign w_addr_out           = w_bin_q[ADDR_WIDTH-1:0];
    assign w_ptr_gray_out       = w_gray_q;
    assign ctrl_almost_full_out = (state_q != ST_NORMAL);
    assign w_level_out          = level_q;
    assign w_overflow_out       = overflow_q;

endmodule

// File: tb/tb_write_ptr_full_ctrl.sv
// Bench for write_ptr_full_ctrl: directed scenarios plus random traffic against an
// occupancy-count reference model.
module tb_write_ptr_full_ctrl;

    logic       clk;
    logic       rst;
    logic       req;
    int         r_bin;
    logic [3:0] r_gray;
    logic       w_en_out;
    logic [2:0] w_addr_out;
    logic [3:0] w_ptr_gray_out;
    logic       ctrl_full_out;
    logic       ctrl_almost_full_out;
    logic [3:0] w_level_out;
    logic       w_overflow_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: write count modulo 16, level as plain difference.
    int         m_w     = 0;
    int         m_level = 0;
    bit         m_full  = 0;
    bit         m_af    = 0;
    bit         m_ovf   = 0;
    logic [3:0] m_gray  = 4'd0;

    assign r_gray = 4'(r_bin) ^ (4'(r_bin) >> 1);

    write_ptr_full_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
        .w_clk_in             (clk),
        .w_reset_in           (rst),
        .w_request_in         (req),
        .r_ptr_gray_sync_in   (r_gray),
        .w_en_out             (w_en_out),
        .w_addr_out           (w_addr_out),
        .w_ptr_gray_out       (w_ptr_gray_out),
        .ctrl_full_out        (ctrl_full_out),
        .ctrl_almost_full_out (ctrl_almost_full_out),
        .w_level_out          (w_level_out),
        .w_overflow_out       (w_overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        int en;
        if (rst) begin
            m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0; m_gray = 4'd0;
        end else begin
            en = (req && !m_full) ? 1 : 0;
            if (req && m_full) m_ovf = 1;
            m_w     = (m_w + en) % 16;
            m_level = (m_w - r_bin + 16) % 16;
            m_full  = (m_level == 8);
            m_af    = (m_level >= 6);
            m_gray  = 4'(m_w ^ (m_w >> 1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; r_bin = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (w_en_out !== 1'b0) begin
                n_fail++; $display("FAIL reset_wen: got %0d expected 0", w_en_out);
            end
            tick();
        end
        rst = 1'b0; req = 1'b0;
        n_checks++;
        if ({w_addr_out, w_ptr_gray_out, ctrl_full_out, ctrl_almost_full_out, w_level_out, w_overflow_out} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d gray=%0d full=%0d af=%0d lvl=%0d ovf=%0d expected all 0",
                     w_addr_out, w_ptr_gray_out, ctrl_full_out, ctrl_almost_full_out, w_level_out, w_overflow_out);
        end
        $display("reset: addr=%0d level=%0d full=%0d", w_addr_out, w_level_out, ctrl_full_out);
    endtask

    task automatic test_fill();
        req = 1'b1; r_bin = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (w_addr_out !== 3'(i) || w_en_out !== 1'b1) begin
                n_fail++; $display("FAIL fill_addr: got addr=%0d en=%0d expected addr=%0d en=1", w_addr_out, w_en_out, i);
            end
            tick();
            n_checks++;
            if (ctrl_almost_full_out !== (i >= 5) || ctrl_full_out !== (i == 7) || w_level_out !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_flags: got af=%0d full=%0d lvl=%0d expected af=%0d full=%0d lvl=%0d",
                         ctrl_almost_full_out, ctrl_full_out, w_level_out, (i >= 5), (i == 7), i + 1);
            end
            $display("fill write %0d: level=%0d af=%0d full=%0d", i, w_level_out, ctrl_almost_full_out, ctrl_full_out);
        end
        n_checks++;
        if (w_ptr_gray_out !== 4'b1100) begin
            n_fail++; $display("FAIL fill_gray: got %b expected 1100", w_ptr_gray_out);
        end
    endtask

    task automatic test_overflow();
        req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (w_en_out !== 1'b0) begin
                n_fail++; $display("FAIL ovf_wen: got %0d expected 0", w_en_out);
            end
            tick();
            n_checks++;
            if (w_overflow_out !== 1'b1 || w_addr_out !== 3'd0 || w_ptr_gray_out !== 4'b1100) begin
                n_fail++;
                $display("FAIL ovf_hold: got ovf=%0d addr=%0d gray=%b expected ovf=1 addr=0 gray=1100",
                         w_overflow_out, w_addr_out, w_ptr_gray_out);
            end
            $display("overflow attempt %0d: ovf=%0d level=%0d", i, w_overflow_out, w_level_out);
        end
        req = 1'b0;
        tick();
        n_checks++;
        if (w_overflow_out !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %0d expected 1", w_overflow_out);
        end
    endtask

    task automatic test_drain();
        req = 1'b0; r_bin = 3;
        tick();
        n_checks++;
        if (ctrl_full_out !== 1'b0 || w_level_out !== 4'd5 || ctrl_almost_full_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got full=%0d lvl=%0d af=%0d expected full=0 lvl=5 af=0",
                     ctrl_full_out, w_level_out, ctrl_almost_full_out);
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        n_checks++;
        if (w_level_out !== 4'd6 || ctrl_almost_full_out !== 1'b1) begin
            n_fail++; $display("FAIL refill: got lvl=%0d af=%0d expected lvl=6 af=1", w_level_out, ctrl_almost_full_out);
        end
        $display("drain: level=%0d af=%0d", w_level_out, ctrl_almost_full_out);
    endtask

    task automatic test_wrap();
        bit saw_zero = 0;
        for (int i = 0; i < 20; i++) begin
            r_bin = (m_w + 15) % 16;
            req   = 1'b1;
            tick();
            n_checks++;
            if (w_level_out !== 4'd2 || ctrl_full_out !== 1'b0) begin
                n_fail++; $display("FAIL wrap_level: got lvl=%0d full=%0d expected lvl=2 full=0", w_level_out, ctrl_full_out);
            end
            if (m_w == 0) begin
                saw_zero = 1;
                n_checks++;
                if (w_ptr_gray_out !== 4'b0000) begin
                    n_fail++; $display("FAIL wrap_gray: got %b expected 0000", w_ptr_gray_out);
                end
            end
            $display("wrap write %0d: gray=%b level=%0d", i, w_ptr_gray_out, w_level_out);
        end
        req = 1'b0;
        n_checks++;
        if (saw_zero !== 1'b1) begin
            n_fail++; $display("FAIL wrap_seen: got %0d expected 1", saw_zero);
        end
    endtask

    task automatic test_mid_reset();
        req   = 1'b0;
        r_bin = (m_w + 11) % 16;
        tick();
        n_checks++;
        if (w_level_out !== 4'd5) begin
            n_fail++; $display("FAIL midrst_pre: got lvl=%0d expected 5", w_level_out);
        end
        rst = 1'b1; req = 1'b1;
        #1;
        n_checks++;
        if (w_en_out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_wen: got %0d expected 0", w_en_out);
        end
        tick();
        n_checks++;
        if ({w_addr_out, w_ptr_gray_out, ctrl_full_out, ctrl_almost_full_out, w_level_out, w_overflow_out} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got addr=%0d gray=%0d full=%0d af=%0d lvl=%0d ovf=%0d expected all 0",
                     w_addr_out, w_ptr_gray_out, ctrl_full_out, ctrl_almost_full_out, w_level_out, w_overflow_out);
        end
        $display("mid reset: addr=%0d level=%0d ovf=%0d", w_addr_out, w_level_out, w_overflow_out);
        rst = 1'b0; req = 1'b0; r_bin = 0;
        tick();
    endtask

    task automatic test_random();
        bit exp_en;
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) < 2);
            if (rst) r_bin = 0;
            else if (((m_w - r_bin + 16) % 16) > 0 && $urandom_range(0, 9) < 4) r_bin = (r_bin + 1) % 16;
            #1;
            exp_en = req && !m_full && !rst;
            n_checks++;
            if (w_en_out !== exp_en || w_addr_out !== 3'(m_w % 8)) begin
                n_fail++;
                $display("FAIL rand_comb: got en=%0d addr=%0d expected en=%0d addr=%0d", w_en_out, w_addr_out, exp_en, m_w % 8);
            end
            tick();
            n_checks++;
            if (ctrl_full_out !== m_full || ctrl_almost_full_out !== m_af || w_level_out !== 4'(m_level)
                || w_overflow_out !== m_ovf || w_ptr_gray_out !== m_gray) begin
                n_fail++;
                $display("FAIL rand_state: got full=%0d af=%0d lvl=%0d ovf=%0d gray=%b expected full=%0d af=%0d lvl=%0d ovf=%0d gray=%b",
                         ctrl_full_out, ctrl_almost_full_out, w_level_out, w_overflow_out, w_ptr_gray_out,
                         m_full, m_af, m_level, m_ovf, m_gray);
            end
            $display("rand %0d: req=%0d rst=%0d rptr=%0d level=%0d full=%0d", i, req, rst, r_bin, w_level_out, ctrl_full_out);
        end
        rst = 1'b0; req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; r_bin = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
